// File: rtl/subsurf_host_if.sv
// Host loader/unloader for the three subsurf RAM banks: streams host words into
// ram0/ram1, kicks the core, waits for it to finish, then streams ram2 back out.
module subsurf_host_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic [9:0]        load_cnt0,
    input  logic [9:0]        load_cnt1,
    input  logic [9:0]        dump_cnt,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              hif_busy,
    output logic              done,
    output logic              core_start,
    input  logic              core_busy,
    input  logic              core_en0,
    input  logic              core_en1,
    input  logic              core_en2,
    input  logic [ADDR_W-1:0] core_a0,
    input  logic [ADDR_W-1:0] core_a1,
    input  logic [ADDR_W-1:0] core_a2,
    input  logic [3:0]        core_we0,
    input  logic [3:0]        core_we1,
    input  logic [3:0]        core_we2,
    input  logic [DATA_W-1:0] core_di0,
    input  logic [DATA_W-1:0] core_di1,
    input  logic [DATA_W-1:0] core_di2,
    output logic              ram_en0,
    output logic              ram_en1,
    output logic              ram_en2,
    output logic [ADDR_W-1:0] ram_a0,
    output logic [ADDR_W-1:0] ram_a1,
    output logic [ADDR_W-1:0] ram_a2,
    output logic [3:0]        ram_we0,
    output logic [3:0]        ram_we1,
    output logic [3:0]        ram_we2,
    output logic [DATA_W-1:0] ram_di0,
    output logic [DATA_W-1:0] ram_di1,
    output logic [DATA_W-1:0] ram_di2,
    input  logic [DATA_W-1:0] ram_do0,
    input  logic [DATA_W-1:0] ram_do1,
    input  logic [DATA_W-1:0] ram_do2
);
    localparam int CNT_W = 10;

    typedef enum logic [2:0] {
        IDLE, LOAD0, LOAD1, START, RUN, DUMP_RD, DUMP_OUT, FIN
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [CNT_W-1:0]   cnt0_reg;
    logic [CNT_W-1:0]   cnt1_reg;
    logic [CNT_W-1:0]   dcnt_reg;
    logic               busy_seen_reg;
    logic               first_reg;
    logic [DATA_W-1:0]  out_data_reg;
    logic [CNT_W-1:0]   cnt0_next;
    logic [CNT_W-1:0]   cnt1_next;
    logic [CNT_W-1:0]   dcnt_next;
    logic               last_word;

    function automatic logic [CNT_W-1:0] clamp(input logic [CNT_W-1:0] c);
        return (c > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : c;
    endfunction

    assign cnt0_next = clamp(load_cnt0);
    assign cnt1_next = clamp(load_cnt1);
    assign dcnt_next = clamp(dump_cnt);
    assign last_word = (cnt_reg == dcnt_reg - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            cnt0_reg      <= '0;
            cnt1_reg      <= '0;
            dcnt_reg      <= '0;
            busy_seen_reg <= 1'b0;
            first_reg     <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            first_reg <= 1'b0;
            case (state_reg)
                IDLE: if (go) begin
                    cnt0_reg      <= cnt0_next;
                    cnt1_reg      <= cnt1_next;
                    dcnt_reg      <= dcnt_next;
                    cnt_reg       <= '0;
                    busy_seen_reg <= 1'b0;
                    if (cnt0_next != '0)      state_reg <= LOAD0;
                    else if (cnt1_next != '0) state_reg <= LOAD1;
                    else                      state_reg <= START;
                end
                LOAD0: if (in_valid) begin
                    if (cnt_reg == cnt0_reg - CNT_W'(1)) begin
                        cnt_reg   <= '0;
                        state_reg <= (cnt1_reg != '0) ? LOAD1 : START;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                LOAD1: if (in_valid) begin
                    if (cnt_reg == cnt1_reg - CNT_W'(1)) begin
                        cnt_reg   <= '0;
                        state_reg <= START;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                START: state_reg <= RUN;
                RUN: begin
                    // A start with a core that has not yet raised busy must not end the run.
                    if (core_busy) begin
                        busy_seen_reg <= 1'b1;
                    end else if (busy_seen_reg) begin
                        busy_seen_reg <= 1'b0;
                        state_reg     <= (dcnt_reg != '0) ? DUMP_RD : FIN;
                    end
                end
                DUMP_RD: begin
                    first_reg <= 1'b1;
                    state_reg <= DUMP_OUT;
                end
                DUMP_OUT: begin
                    if (first_reg) out_data_reg <= ram_do2;
                    if (out_ready) begin
                        if (last_word) begin
                            cnt_reg   <= '0;
                            state_reg <= FIN;
                        end else begin
                            cnt_reg   <= cnt_reg + CNT_W'(1);
                            state_reg <= DUMP_RD;
                        end
                    end
                end
                FIN: state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state_reg == LOAD0) || (state_reg == LOAD1);
    assign hif_busy   = (state_reg != IDLE);
    assign done       = (state_reg == FIN);
    assign core_start = (state_reg == START);
    assign out_valid  = (state_reg == DUMP_OUT);
    assign out_last   = (state_reg == DUMP_OUT) && last_word;
    // RAM data arrives in the first DUMP_OUT cycle; later stalled cycles replay the captured copy.
    assign out_data   = first_reg ? ram_do2 : out_data_reg;

    logic [2:0]                   core_en_v;
    logic [2:0][ADDR_W-1:0]       core_a_v;
    logic [2:0][3:0]              core_we_v;
    logic [2:0][DATA_W-1:0]       core_di_v;
    logic [2:0]                   ram_en_v;
    logic [2:0][ADDR_W-1:0]       ram_a_v;
    logic [2:0][3:0]              ram_we_v;
    logic [2:0][DATA_W-1:0]       ram_di_v;
    logic [2:0]                   load_sel;
    logic [2:0]                   rd_sel;

    assign core_en_v = {core_en2, core_en1, core_en0};
    assign core_a_v  = {core_a2, core_a1, core_a0};
    assign core_we_v = {core_we2, core_we1, core_we0};
    assign core_di_v = {core_di2, core_di1, core_di0};
    assign load_sel  = {1'b0, state_reg == LOAD1, state_reg == LOAD0};
    assign rd_sel    = {state_reg == DUMP_RD, 2'b00};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_bank
            always_comb begin
                ram_en_v[gi] = 1'b0;
                ram_a_v[gi]  = '0;
                ram_we_v[gi] = '0;
                ram_di_v[gi] = '0;
                if (state_reg == RUN) begin
                    ram_en_v[gi] = core_en_v[gi];
                    ram_a_v[gi]  = core_a_v[gi];
                    ram_we_v[gi] = core_we_v[gi];
                    ram_di_v[gi] = core_di_v[gi];
                end else if (load_sel[gi] && in_valid) begin
                    ram_en_v[gi] = 1'b1;
                    ram_a_v[gi]  = cnt_reg[ADDR_W-1:0];
                    ram_we_v[gi] = 4'hF;
                    ram_di_v[gi] = in_data;
                end else if (rd_sel[gi]) begin
                    ram_en_v[gi] = 1'b1;
                    ram_a_v[gi]  = cnt_reg[ADDR_W-1:0];
                end
            end
        end
    endgenerate

    assign {ram_en2, ram_en1, ram_en0} = ram_en_v;
    assign {ram_a2, ram_a1, ram_a0}    = ram_a_v;
    assign {ram_we2, ram_we1, ram_we0} = ram_we_v;
    assign {ram_di2, ram_di1, ram_di0} = ram_di_v;

    // ram0/ram1 read data goes straight to the core, never through this block.
    logic unused_rd;
    assign unused_rd = ^{ram_do0, ram_do1};
endmodule

// File: tb/tb_subsurf_host_if.sv
// Randomized bench for subsurf_host_if: RAM banks modelled behaviourally, a toy core
// drives busy and ram2 writes, and expectations come from word queues and an image of ram2.
module tb_subsurf_host_if;
    logic        clk = 1'b0;
    logic        rst, go, in_valid, out_ready, core_busy;
    logic [9:0]  load_cnt0, load_cnt1, dump_cnt;
    logic [31:0] in_data;
    logic        in_ready, out_valid, out_last, hif_busy, done, core_start;
    logic [31:0] out_data;
    logic        core_en0, core_en1, core_en2;
    logic [8:0]  core_a0, core_a1, core_a2;
    logic [3:0]  core_we0, core_we1, core_we2;
    logic [31:0] core_di0, core_di1, core_di2;
    logic        ram_en0, ram_en1, ram_en2;
    logic [8:0]  ram_a0, ram_a1, ram_a2;
    logic [3:0]  ram_we0, ram_we1, ram_we2;
    logic [31:0] ram_di0, ram_di1, ram_di2;
    logic [31:0] ram_do0, ram_do1, ram_do2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    subsurf_host_if dut (
        .clk(clk), .rst(rst), .go(go),
        .load_cnt0(load_cnt0), .load_cnt1(load_cnt1), .dump_cnt(dump_cnt),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .hif_busy(hif_busy), .done(done), .core_start(core_start), .core_busy(core_busy),
        .core_en0(core_en0), .core_en1(core_en1), .core_en2(core_en2),
        .core_a0(core_a0), .core_a1(core_a1), .core_a2(core_a2),
        .core_we0(core_we0), .core_we1(core_we1), .core_we2(core_we2),
        .core_di0(core_di0), .core_di1(core_di1), .core_di2(core_di2),
        .ram_en0(ram_en0), .ram_en1(ram_en1), .ram_en2(ram_en2),
        .ram_a0(ram_a0), .ram_a1(ram_a1), .ram_a2(ram_a2),
        .ram_we0(ram_we0), .ram_we1(ram_we1), .ram_we2(ram_we2),
        .ram_di0(ram_di0), .ram_di1(ram_di1), .ram_di2(ram_di2),
        .ram_do0(ram_do0), .ram_do1(ram_do1), .ram_do2(ram_do2)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Behavioural RAM banks with one-cycle registered read; pre_* is a backdoor for ram2.
    logic [31:0] mem0 [512];
    logic [31:0] mem1 [512];
    logic [31:0] mem2 [512];
    logic        pre_we = 1'b0;
    logic [8:0]  pre_a = '0;
    logic [31:0] pre_d = '0;
    int          wr_cnt0 = 0, wr_cnt1 = 0, wr_cnt2 = 0;

    always @(posedge clk) begin
        if (ram_en0) begin
            mem0[ram_a0] <= merge(mem0[ram_a0], ram_di0, ram_we0);
            ram_do0 <= mem0[ram_a0];
            if (ram_we0 != 0) wr_cnt0 <= wr_cnt0 + 1;
        end
        if (ram_en1) begin
            mem1[ram_a1] <= merge(mem1[ram_a1], ram_di1, ram_we1);
            ram_do1 <= mem1[ram_a1];
            if (ram_we1 != 0) wr_cnt1 <= wr_cnt1 + 1;
        end
        if (ram_en2) begin
            mem2[ram_a2] <= merge(mem2[ram_a2], ram_di2, ram_we2);
            ram_do2 <= mem2[ram_a2];
            if (ram_we2 != 0) wr_cnt2 <= wr_cnt2 + 1;
        end
        if (pre_we) mem2[pre_a] <= pre_d;
    end

    logic [31:0] exp_ram2 [512];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic core_idle();
        core_en0 = 0; core_en1 = 0; core_en2 = 0;
        core_we0 = 0; core_we1 = 0; core_we2 = 0;
        core_a0 = 0; core_a1 = 0; core_a2 = 0;
        core_di0 = 0; core_di1 = 0; core_di2 = 0;
    endtask

    task automatic core_junk();
        core_en0 = 1'($urandom); core_en1 = 1'($urandom); core_en2 = 1'($urandom);
        core_we0 = 4'($urandom); core_we1 = 4'($urandom); core_we2 = 4'($urandom);
        core_a0 = 9'($urandom); core_a1 = 9'($urandom); core_a2 = 9'($urandom);
        core_di0 = $urandom; core_di1 = $urandom; core_di2 = $urandom;
    endtask

    task automatic preload2(input int a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1; pre_a = 9'(a); pre_d = d;
        exp_ram2[a] = d;
        @(negedge clk);
        pre_we = 0;
    endtask

    // One complete go..done sequence; stall_idx selects a dump word held off for 5 cycles.
    task automatic run_seq(input int c0, input int c1, input int dc, input bit dir_data,
                           input bit core_wr, input int stall_idx);
        int e0, e1, ed, didx, cyc, starts, bl, wstep, core_w2, stalls;
        int w0, w1, w2;
        logic [31:0] acc[$];
        bit hold, started, fin;
        logic [31:0] hd, wd;
        logic hl;
        logic [8:0] wa;
        logic [3:0] wwe;
        e0 = (c0 > 512) ? 512 : c0;
        e1 = (c1 > 512) ? 512 : c1;
        ed = (dc > 512) ? 512 : dc;
        didx = 0; cyc = 0; starts = 0; bl = 0; wstep = 0; core_w2 = 0; stalls = 0;
        hold = 0; started = 0; fin = 0; hd = 0; hl = 0;
        w0 = wr_cnt0; w1 = wr_cnt1; w2 = wr_cnt2;

        @(negedge clk);
        load_cnt0 = 10'(c0); load_cnt1 = 10'(c1); dump_cnt = 10'(dc);
        go = 1; core_junk();
        @(negedge clk);
        go = 0;
        check("first_ready", in_ready, (e0 + e1) > 0);
        check("first_start", core_start, (e0 + e1) == 0);

        while (!fin && cyc < 4000) begin
            // Input stream: inputs driven now are sampled with the state visible now.
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = dir_data ? 32'(10 + acc.size()) : $urandom;
            if (in_ready && in_valid) acc.push_back(in_data);

            // Output stream
            if (hold) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, hd);
                check("hold_last", out_last, hl);
                hold = 0;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            if (out_valid) begin
                if (didx < ed) begin
                    check("dump_data", out_data, exp_ram2[didx]);
                    check("dump_last", out_last, didx == ed - 1);
                end else begin
                    check("extra_word", 1, 0);
                end
                if (didx == stall_idx && stalls < 5) begin
                    out_ready = 0;
                    stalls++;
                end
                if (out_ready) didx++;
                else begin hold = 1; hd = out_data; hl = out_last; end
            end

            // Toy core
            if (core_start) begin
                starts++;
                if (!started) begin
                    started = 1; core_busy = 1; bl = $urandom_range(2, 5);
                end
                core_idle();
            end else if (started && core_busy) begin
                core_idle();
                if (core_wr && wstep < 2) begin
                    wa  = (wstep == 0) ? 9'd5 : 9'($urandom_range(0, 7));
                    wd  = (wstep == 0) ? 32'h55 : $urandom;
                    wwe = (wstep == 0) ? 4'hF : 4'($urandom);
                    core_en2 = 1; core_a2 = wa; core_di2 = wd; core_we2 = wwe;
                    exp_ram2[wa] = merge(exp_ram2[wa], wd, wwe);
                    if (wwe != 0) core_w2++;
                    wstep++;
                end
                bl--;
                if (bl == 0) core_busy = 0;
            end else if (!started) begin
                core_junk();
            end else begin
                core_idle();
            end

            if (done) begin
                check("done_core_idle", core_busy, 0);
                check("done_words", acc.size(), e0 + e1);
                check("done_dumped", didx, ed);
                check("fin_busy", hif_busy, 1);
                fin = 1;
                go = 0;
            end else begin
                go = ($urandom_range(0, 7) == 0);
            end
            cyc++;
            @(negedge clk);
        end
        go = 0; in_valid = 0; core_busy = 0; out_ready = 0; core_idle();
        if (!fin) begin
            check("timeout", 1, 0);
            rst = 1;
            @(negedge clk);
            rst = 0;
        end else begin
            check("idle_busy", hif_busy, 0);
            check("done_pulse", done, 0);
            check("start_pulses", starts, 1);
            check("wr_bank0", wr_cnt0 - w0, e0);
            check("wr_bank1", wr_cnt1 - w1, e1);
            check("wr_bank2", wr_cnt2 - w2, core_w2);
            if (acc.size() == e0 + e1) begin
                for (int i = 0; i < e0; i++) check("ram0_word", mem0[i], acc[i]);
                for (int i = 0; i < e1; i++) check("ram1_word", mem1[i], acc[e0 + i]);
            end
        end
        $display("SEQ cnt0=%0d cnt1=%0d dump=%0d loaded=%0d dumped=%0d cycles=%0d",
                 c0, c1, dc, acc.size(), didx, cyc);
    endtask

    initial begin
        rst = 1; go = 0; in_valid = 0; in_data = 0; out_ready = 0; core_busy = 0;
        load_cnt0 = 0; load_cnt1 = 0; dump_cnt = 0;
        core_idle();
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_hif_busy", hif_busy, 0);
        check("rst_done", done, 0);
        check("rst_core_start", core_start, 0);
        check("rst_out_data", out_data, 0);
        check("rst_ram_en", {ram_en2, ram_en1, ram_en0}, 0);
        rst = 0;

        for (int a = 0; a < 512; a++) preload2(a, $urandom);

        // Directed: load and run with words A..E
        run_seq(3, 2, 0, 1, 0, -1);
        check("ram0_2_C", mem0[2], 32'hC);
        check("ram1_1_E", mem1[1], 32'hE);

        // Directed: dump 1..4 with a 5-cycle stall on the second word
        for (int a = 0; a < 4; a++) preload2(a, 32'(a + 1));
        run_seq(0, 0, 4, 0, 0, 1);

        // Zero counts, clamp, and core write during RUN dumped back
        run_seq(0, 0, 0, 0, 0, -1);
        run_seq(600, 0, 0, 0, 0, -1);
        run_seq(4, 0, 8, 0, 1, -1);

        // Reset in the middle of LOAD1
        @(negedge clk);
        load_cnt0 = 2; load_cnt1 = 5; dump_cnt = 0; go = 1;
        @(negedge clk);
        go = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_data = 32'(100 + i);
            @(negedge clk);
        end
        in_valid = 0; rst = 1;
        @(negedge clk);
        rst = 0;
        check("mrst_in_ready", in_ready, 0);
        check("mrst_hif_busy", hif_busy, 0);
        check("mrst_done", done, 0);
        check("mrst_core_start", core_start, 0);
        check("mrst_out_valid", out_valid, 0);
        check("mrst_ram_en", {ram_en2, ram_en1, ram_en0}, 0);
        check("mrst_ram0_1", mem0[1], 32'd101);
        check("mrst_ram1_1", mem1[1], 32'd103);
        @(negedge clk);
        check("mrst_no_done", done, 0);
        run_seq(2, 3, 3, 0, 1, -1);

        for (int k = 0; k < 10; k++)
            run_seq($urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 20),
                    0, 1'($urandom), $urandom_range(0, 5));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/subsurf_host_if.md
# subsurf_host_if

Host-side loader/unloader that owns the three DFFRAM512x32 banks around the `subsurf` core. It streams input words from a host into ram0 and ram1, then hands the banks to the core with a one-cycle `start` pulse. When the core drops `busy`, it streams the results back out of ram2. It sits between the chip's host port and the existing RAMs/core, and is the write side of the core's read path and the read side of the core's write path.

## Interface
- `ADDR_W`, 9, RAM address width.
- `DATA_W`, 32, RAM word width.
- `DEPTH`, 512, words per bank; counts are clamped to this.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `go` input 1: one-cycle request to start a load/run/dump sequence; sampled only in IDLE.
- `load_cnt0`, `load_cnt1` input 10: words to load into ram0 / ram1, 0..512.
- `dump_cnt` input 10: words to read from ram2, 0..512.
- `in_valid` input 1 / `in_ready` output 1 / `in_data` input 32: host input stream.
- `out_valid` output 1 / `out_ready` input 1 / `out_data` output 32 / `out_last` output 1: host output stream.
- `hif_busy` output 1: high whenever state != IDLE.
- `done` output 1: one-cycle pulse on return to IDLE.
- `core_start` output 1: drives `subsurf.start`.
- `core_busy` input 1: from `subsurf.busy`.
- `core_en{0,1,2}` input 1, `core_a{0,1,2}` input 9, `core_we{0,1,2}` input 4, `core_di{0,1,2}` input 32: core-side RAM requests.
- `ram_en{0,1,2}` output 1, `ram_a{0,1,2}` output 9, `ram_we{0,1,2}` output 4, `ram_di{0,1,2}` output 32: to the RAM macros.
- `ram_do{0,1,2}` input 32: RAM read data, also wired straight to the core's `do0..2`.

## Operation
- States: IDLE, LOAD0, LOAD1, START, RUN, DUMP_RD, DUMP_OUT, FIN.
- IDLE:
  - On `go`, latch the three counts (each clamped to 512) and clear the word counter.
  - Next state is the first applicable of LOAD0 (cnt0>0), LOAD1 (cnt1>0), START.
- LOAD0/LOAD1:
  - `in_ready`=1.
  - On `in_valid`, the selected bank gets `ram_en`=1, `ram_we`=4'hF, `ram_a`=word counter, `ram_di`=`in_data` (combinational from `in_valid`/`in_data`), and the counter increments.
  - After the final word, clear the counter and advance: LOAD0→LOAD1 (or START if cnt1=0); LOAD1→START.
- START: `core_start`=1 for exactly one cycle, then go to RUN.
- RUN:
  - RAM ports are a pass-through of `core_*` for all three banks.
  - A `busy_seen` flag sets when `core_busy`=1.
  - Exit to DUMP_RD (or FIN if dump_cnt=0) on the first cycle where `core_busy`=0 and `busy_seen`=1.
- DUMP_RD: `ram_en2`=1, `ram_we2`=0, `ram_a2`=counter; go to DUMP_OUT.
- DUMP_OUT:
  - `out_data` registers `ram_do2` on entry.
  - `out_valid`=1 is held until `out_ready`; `out_last`=1 on word dump_cnt−1.
  - On handshake, the counter increments; go to DUMP_RD, or to FIN after the last word.
- FIN: `done`=1, go to IDLE.
- In every state except RUN, the RAM ports are driven only by this block. Unused bank ports carry en=0, we=0, a=0, di=0. The core's requests are ignored outside RUN.
- `go` outside IDLE is ignored. `in_valid` outside the LOAD states is never accepted.

## Timing
- Reset: state IDLE; `in_ready`, `out_valid`, `out_last`, `hif_busy`, `done` and `core_start` are 0; `out_data`=0; counter and `busy_seen` cleared. RAM ports are muxed from the IDLE state, so all are 0.
- A `rst` mid-sequence returns to IDLE the next cycle. RAM contents are left untouched and no `done` is issued.
- `go` at edge N puts the block in the first LOAD state at N+1. The first word can be accepted in that cycle.
- Load throughput is 1 word/cycle.
- RAM read latency is 1 cycle. Dump throughput is 1 word per 2 cycles at best. Under backpressure, `out_data`/`out_valid`/`out_last` hold stable.
- `core_start` pulses 1 cycle after the last load write. The core must raise `busy` within 1 cycle of `start`.
- A counter at 512 words is 10 bits; the address uses counter[8:0]. No wrap occurs because counts are clamped.

## Test plan
- Load and run: `go` with cnt0=3, cnt1=2, dump=0; stream 0xA,0xB,0xC,0xD,0xE.
  - Required: ram0[0..2]=A,B,C and ram1[0..1]=D,E.
  - `core_start` is a single pulse, and `done` follows once `core_busy` falls.
- Dump: preload ram2[0..3]=1,2,3,4, all counts 0 except dump=4.
  - Required: `out_data` 1,2,3,4, with `out_last` only on 4.
  - Hold `out_ready`=0 for 5 cycles on word 2; the value stays 2 with `out_valid` held.
- Zero counts: cnt0=cnt1=dump=0 → `core_start` at go+1; `done` after busy low; no RAM writes.
- Clamp: cnt0=600 → exactly 512 writes, addresses 0..511; LOAD0 then exits.
- Mux isolation: toggle `core_en0`/`core_we0` during LOAD0 → no effect on ram0. During RUN, the core writes ram2[5]=0x55 and it is dumped correctly.
- Reset mid-LOAD1 → all outputs 0 next cycle. `go` then restarts cleanly.
